// File: rtl/hpm_overflow_unit.sv
// hpm_overflow_unit
//
// Overflow companion to the HPM counter block. It watches each counter's
// increment strobe and current value, keeps a sticky overflow (OF) bit per
// counter, raises the local counter-overflow interrupt (LCOFI) pending request
// and holds the per-counter mode-inhibit bits (MINH/SINH/UINH).
//
// Counter i maps to mhpmcounter(3+i). Its OF/MINH/SINH/UINH bits live in the
// top four bits of mhpmevent(3+i) (RV64) or mhpmevent(3+i)h (RV32).
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   debug_mode_i       core in debug mode; suppresses OF setting
//   priv_lvl_i         current privilege (11=M, 01=S, 00=U, 10 reserved)
//   cnt_inc_i          per-counter increment strobe (already inhibit-gated)
//   cnt_val_i          per-counter current value, 64 bits each, counter 0 in LSBs
//   csr_addr_i/we_i/wdata_i   CSR access
//   csr_rdata_o        combinational read data for csr_addr_i
//   csr_hit_o          csr_addr_i decodes to a register owned here
//   mode_inhibit_o     counter i must not count at priv_lvl_i
//   of_o               sticky OF bits
//   lcofi_pending_o    LCOFI pending request
//   lcofi_clr_i        software clear of LCOFI pending
module hpm_overflow_unit #(
  parameter int NumCounters = 6,
  parameter int XLEN        = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      debug_mode_i,
  input  logic [1:0]                priv_lvl_i,
  input  logic [NumCounters-1:0]    cnt_inc_i,
  input  logic [NumCounters*64-1:0] cnt_val_i,
  input  logic [11:0]               csr_addr_i,
  input  logic                      csr_we_i,
  input  logic [XLEN-1:0]           csr_wdata_i,
  output logic [XLEN-1:0]           csr_rdata_o,
  output logic                      csr_hit_o,
  output logic [NumCounters-1:0]    mode_inhibit_o,
  output logic [NumCounters-1:0]    of_o,
  output logic                      lcofi_pending_o,
  input  logic                      lcofi_clr_i
);

  localparam logic [11:0] SCOUNTOVF_ADDR = 12'hDA0;
  // The event CSR carrying the owned bits differs between RV64 and RV32.
  localparam logic [11:0] EVT_BASE_ADDR  = (XLEN == 64) ? 12'h323 : 12'h723;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } lcofi_state_e;

  lcofi_state_e state_reg, state_next;

  logic [NumCounters-1:0] of_reg, of_next;
  logic [NumCounters-1:0] minh_reg, minh_next;
  logic [NumCounters-1:0] sinh_reg, sinh_next;
  logic [NumCounters-1:0] uinh_reg, uinh_next;

  logic [NumCounters-1:0] evt_sel;  // address selects counter i's event CSR
  logic [NumCounters-1:0] evt_wr;   // write to counter i's owned bits
  logic [NumCounters-1:0] wrap;
  logic [NumCounters-1:0] rise;
  logic                   any_rise;

  genvar gi;
  generate
    for (gi = 0; gi < NumCounters; gi++) begin : g_cnt
      localparam logic [11:0] EVT_ADDR = EVT_BASE_ADDR + 12'(gi);

      assign evt_sel[gi] = (csr_addr_i == EVT_ADDR);
      assign evt_wr[gi]  = csr_we_i & evt_sel[gi];

      assign wrap[gi] = cnt_inc_i[gi] & (cnt_val_i[gi*64 +: 64] == 64'hFFFF_FFFF_FFFF_FFFF);

      // A CSR write to the same counter in the same cycle owns OF and
      // suppresses the rise, so software sees exactly the value it wrote.
      assign rise[gi] = wrap[gi] & ~of_reg[gi] & ~debug_mode_i & ~evt_wr[gi];

      assign of_next[gi]   = evt_wr[gi] ? csr_wdata_i[XLEN-1]
                                        : (of_reg[gi] | (wrap[gi] & ~debug_mode_i));
      assign minh_next[gi] = evt_wr[gi] ? csr_wdata_i[XLEN-2] : minh_reg[gi];
      assign sinh_next[gi] = evt_wr[gi] ? csr_wdata_i[XLEN-3] : sinh_reg[gi];
      assign uinh_next[gi] = evt_wr[gi] ? csr_wdata_i[XLEN-4] : uinh_reg[gi];

      // Reserved privilege 2'b10 matches none of the terms and yields 0.
      assign mode_inhibit_o[gi] = ((priv_lvl_i == 2'b11) & minh_reg[gi])
                                | ((priv_lvl_i == 2'b01) & sinh_reg[gi])
                                | ((priv_lvl_i == 2'b00) & uinh_reg[gi]);
    end
  endgenerate

  assign any_rise = |rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      of_reg    <= '0;
      minh_reg  <= '0;
      sinh_reg  <= '0;
      uinh_reg  <= '0;
      state_reg <= IDLE;
    end else begin
      of_reg    <= of_next;
      minh_reg  <= minh_next;
      sinh_reg  <= sinh_next;
      uinh_reg  <= uinh_next;
      state_reg <= state_next;
    end
  end

  // LCOFI FSM: a new overflow in the same cycle as a software clear wins.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (any_rise) state_next = PEND;
      PEND: if (lcofi_clr_i && !any_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign lcofi_pending_o = (state_reg == PEND);
  assign of_o            = of_reg;

  // On RV64 the low bits of mhpmevent belong to the counter block, so the
  // address is not claimed here even though the top bits are supplied.
  assign csr_hit_o = (csr_addr_i == SCOUNTOVF_ADDR) | ((XLEN == 32) & (|evt_sel));

  always_comb begin
    csr_rdata_o = '0;
    if (csr_addr_i == SCOUNTOVF_ADDR) begin
      csr_rdata_o[3 +: NumCounters] = of_reg;
    end
    for (int i = 0; i < NumCounters; i++) begin
      if (evt_sel[i]) begin
        csr_rdata_o[XLEN-1 -: 4] = {of_reg[i], minh_reg[i], sinh_reg[i], uinh_reg[i]};
      end
    end
  end

  // Only the top four write-data bits are stored here.
  logic unused_wdata;
  assign unused_wdata = ^csr_wdata_i[XLEN-5:0];

endmodule

// File: tb/tb_hpm_overflow_unit.sv
module tb_hpm_overflow_unit;

  localparam int N = 6;
  localparam int XLEN = 64;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              debug_mode_i;
  logic [1:0]        priv_lvl_i;
  logic [N-1:0]      cnt_inc_i;
  logic [N*64-1:0]   cnt_val_i;
  logic [11:0]       csr_addr_i;
  logic              csr_we_i;
  logic [XLEN-1:0]   csr_wdata_i;
  logic [XLEN-1:0]   csr_rdata_o;
  logic              csr_hit_o;
  logic [N-1:0]      mode_inhibit_o;
  logic [N-1:0]      of_o;
  logic              lcofi_pending_o;
  logic              lcofi_clr_i;

  int tests_run = 0;
  int tests_failed = 0;

  hpm_overflow_unit #(.NumCounters(N), .XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .debug_mode_i   (debug_mode_i),
    .priv_lvl_i     (priv_lvl_i),
    .cnt_inc_i      (cnt_inc_i),
    .cnt_val_i      (cnt_val_i),
    .csr_addr_i     (csr_addr_i),
    .csr_we_i       (csr_we_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_hit_o      (csr_hit_o),
    .mode_inhibit_o (mode_inhibit_o),
    .of_o           (of_o),
    .lcofi_pending_o(lcofi_pending_o),
    .lcofi_clr_i    (lcofi_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_val(input int idx, input logic [63:0] v);
    cnt_val_i[idx*64 +: 64] = v;
  endtask

  task automatic wrap_once(input int idx);
    set_val(idx, ALL1);
    cnt_inc_i[idx] = 1'b1;
    tick();
    cnt_inc_i = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_addr_i  = a;
    csr_wdata_i = d;
    csr_we_i    = 1'b1;
    tick();
    csr_we_i    = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    debug_mode_i = 1'b0;
    priv_lvl_i = 2'b11;
    cnt_inc_i = '0;
    cnt_val_i = '0;
    csr_addr_i = 12'h000;
    csr_we_i = 1'b0;
    csr_wdata_i = '0;
    lcofi_clr_i = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_of", 64'(of_o), 64'h0);
    check("rst_pending", 64'(lcofi_pending_o), 64'h0);
    check("rst_inhibit", 64'(mode_inhibit_o), 64'h0);
    rst_i = 1'b0;
    tick();

    // Near-boundary value must not flag
    set_val(1, 64'hFFFF_FFFF_FFFF_FFFE);
    cnt_inc_i[1] = 1'b1;
    tick();
    cnt_inc_i = '0;
    tick();
    check("no_wrap_fffe_of", 64'(of_o), 64'h0);
    check("no_wrap_fffe_pend", 64'(lcofi_pending_o), 64'h0);

    // Overflow on counter 0
    wrap_once(0);
    check("ovf_of", 64'(of_o), 64'h01);
    check("ovf_pending", 64'(lcofi_pending_o), 64'h1);
    csr_addr_i = 12'hDA0;
    #1;
    check("scountovf_rd", csr_rdata_o, 64'h8);
    check("scountovf_hit", 64'(csr_hit_o), 64'h1);

    // Software clear, then sticky OF suppresses a new pending
    lcofi_clr_i = 1'b1;
    tick();
    lcofi_clr_i = 1'b0;
    check("clr_pending", 64'(lcofi_pending_o), 64'h0);
    check("clr_of_kept", 64'(of_o), 64'h01);
    wrap_once(0);
    tick();
    check("sticky_of", 64'(of_o), 64'h01);
    check("sticky_no_pend", 64'(lcofi_pending_o), 64'h0);

    // Clear OF[0] via mhpmevent3, then wrap re-raises
    csr_addr_i = 12'h323;
    #1;
    check("evt3_hit", 64'(csr_hit_o), 64'h0);
    check("evt3_rd_of", csr_rdata_o, 64'h8000_0000_0000_0000);
    csr_write(12'h323, 64'h0);
    check("csr_clr_of", 64'(of_o), 64'h0);
    check("csr_clr_keeps_pend", 64'(lcofi_pending_o), 64'h0);
    wrap_once(0);
    check("rewrap_of", 64'(of_o), 64'h01);
    check("rewrap_pend", 64'(lcofi_pending_o), 64'h1);

    // Clear colliding with a rise on counter 2
    lcofi_clr_i = 1'b1;
    wrap_once(2);
    lcofi_clr_i = 1'b0;
    check("collide_pend", 64'(lcofi_pending_o), 64'h1);
    check("collide_of", 64'(of_o), 64'h05);

    // Asynchronous reset while PEND, away from a clock edge
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_pend", 64'(lcofi_pending_o), 64'h0);
    check("async_rst_of", 64'(of_o), 64'h0);
    rst_i = 1'b0;
    tick();
    tick();
    check("post_rst_idle", 64'(lcofi_pending_o), 64'h0);

    // Inhibit: MINH on counter 1
    priv_lvl_i = 2'b11;
    csr_addr_i = 12'h324;
    csr_wdata_i = 64'h4000_0000_0000_0000;
    csr_we_i = 1'b1;
    #1;
    check("minh_not_yet", 64'(mode_inhibit_o), 64'h0);
    tick();
    csr_we_i = 1'b0;
    check("minh_m", 64'(mode_inhibit_o), 64'h02);
    priv_lvl_i = 2'b00;
    #1;
    check("minh_u", 64'(mode_inhibit_o), 64'h0);
    csr_addr_i = 12'h324;
    #1;
    check("evt4_rd", csr_rdata_o, 64'h4000_0000_0000_0000);
    // UINH on counter 2, SINH on counter 3
    csr_write(12'h325, 64'h1000_0000_0000_0000);
    csr_write(12'h326, 64'h2000_0000_0000_0000);
    priv_lvl_i = 2'b00;
    #1;
    check("uinh_u", 64'(mode_inhibit_o), 64'h04);
    priv_lvl_i = 2'b01;
    #1;
    check("sinh_s", 64'(mode_inhibit_o), 64'h08);
    priv_lvl_i = 2'b10;
    #1;
    check("reserved_priv", 64'(mode_inhibit_o), 64'h0);
    priv_lvl_i = 2'b11;

    // RV32-only high event CSR is not owned on RV64
    csr_addr_i = 12'h723;
    #1;
    check("evt3h_hit", 64'(csr_hit_o), 64'h0);
    check("evt3h_rd", csr_rdata_o, 64'h0);

    // Debug mode blocks OF
    debug_mode_i = 1'b1;
    wrap_once(5);
    debug_mode_i = 1'b0;
    tick();
    check("debug_of", 64'(of_o), 64'h0);
    check("debug_pend", 64'(lcofi_pending_o), 64'h0);

    // CSR write of OF=0 wins over a simultaneous wrap on counter 5
    set_val(5, ALL1);
    cnt_inc_i[5] = 1'b1;
    csr_write(12'h328, 64'h0);
    cnt_inc_i = '0;
    check("csr_wins_of", 64'(of_o), 64'h0);
    tick();
    check("csr_wins_pend", 64'(lcofi_pending_o), 64'h0);

    // CSR set of OF does not raise pending; scountovf write ignored
    csr_write(12'h328, 64'h8000_0000_0000_0000);
    tick();
    check("csr_set_of", 64'(of_o), 64'h20);
    check("csr_set_no_pend", 64'(lcofi_pending_o), 64'h0);
    csr_write(12'hDA0, ALL1);
    csr_addr_i = 12'hDA0;
    #1;
    check("scountovf_ro", csr_rdata_o, 64'h100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hpm_overflow_unit.md
Name: hpm_overflow_unit

Overview:
- Sscofpmf companion to the HPM counter block: sits directly downstream of counters mhpmcounter3..(3+NumCounters-1).
- Watches each counter's increment strobe and current value, and sets a sticky per-counter overflow (OF) bit on 64-bit wrap.
- Raises the local counter-overflow interrupt (LCOFI) pending request.
- Holds the mode-inhibit bits (MINH/SINH/UINH) and returns per-counter inhibit masks that gate counter increments upstream.

Parameters:
NumCounters, 6, number of HPM counters covered (counter i maps to mhpmcounter(3+i)), range 1..29
XLEN, 64, CSR data width, 32 or 64

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
debug_mode_i  in  1  core in debug mode; blocks OF setting
priv_lvl_i  in  2  current privilege: 2'b11=M, 2'b01=S, 2'b00=U
cnt_inc_i  in  NumCounters  counter i increments this cycle (post-inhibit)
cnt_val_i  in  NumCounters*64  current registered value of counter i
csr_addr_i  in  12  CSR address
csr_we_i  in  1  CSR write strobe, single cycle
csr_wdata_i  in  XLEN  CSR write data
csr_rdata_o  out  XLEN  combinational read data for csr_addr_i
csr_hit_o  out  1  csr_addr_i decodes to a register owned here
mode_inhibit_o  out  NumCounters  counter i must not count at priv_lvl_i
of_o  out  NumCounters  sticky OF bits
lcofi_pending_o  out  1  LCOFI pending request to interrupt controller
lcofi_clr_i  in  1  software clear of LCOFI pending (mip write, bit 13 = 0)

Behaviour:
- Reset (rst_i=1, asynchronous):
  - All OF/MINH/SINH/UINH bits = 0.
  - FSM = IDLE.
  - lcofi_pending_o = 0, of_o = 0, mode_inhibit_o = 0.
- Per-counter state: OF, MINH, SINH, UINH. Stored at bits 63,62,61,60 of mhpmevent(3+i) for RV64. For RV32 they sit at bits 31..28 of mhpmevent(3+i)h.
- CSR map:
  - mhpmevent3h = 0x723+i (RV32 only).
  - scountovf = 0xDA0: read-only; bit (3+i) = OF[i], other bits 0.
  - mhpmevent3 = 0x323+i: only bits 63:60 are owned here (RV64). Reads return those bits in place, zeros elsewhere. Low bits belong to the counter block; csr_hit_o=0 for this address.
  - mhpmevent3h: csr_hit_o=1. Access with XLEN=64 → csr_hit_o=0, rdata=0.
  - Writes to scountovf are ignored.
- Overflow detect, combinational: wrap[i] = cnt_inc_i[i] & (cnt_val_i[i] == 64'hFFFF_FFFF_FFFF_FFFF).
  - Next cycle: OF[i] <= 1 if wrap[i] & !debug_mode_i.
  - Once set, OF stays 1 until cleared by a CSR write.
- Rising edge: rise[i] = wrap[i] & !OF[i] & !debug_mode_i. A wrap while OF is already 1 sets nothing new and does not re-raise LCOFI.
- Simultaneous CSR write and wrap on the same counter: the CSR write value wins for OF, and no rise is generated that cycle.
- Inhibit: mode_inhibit_o[i] = (priv_lvl_i==M & MINH[i]) | (priv_lvl_i==S & SINH[i]) | (priv_lvl_i==U & UINH[i]).
  - Purely combinational from registered bits, so a new inhibit value applies from the cycle after the CSR write.
  - Reserved priv_lvl_i value 2'b10 → 0.
- LCOFI FSM, two states:
  - IDLE: lcofi_pending_o=0. |rise → PEND.
  - PEND: lcofi_pending_o=1. lcofi_clr_i & !(|rise) → IDLE. lcofi_clr_i & |rise → stay PEND (the new overflow wins). Otherwise hold.
  - lcofi_pending_o is registered: 1-cycle latency from wrap to pending.
  - Clearing OF bits does not clear pending. Setting OF by CSR write does not set pending.
- Wrap-around: a counter wrapping to 0 is the counter block's business; this unit only flags it.

Test Plan:
- Reset mid-PEND: force PEND, assert rst_i asynchronously → lcofi_pending_o=0 and of_o=0 immediately; after release, state is IDLE.
- Overflow: cnt_val_i[0]=64'hFFFF_FFFF_FFFF_FFFF, cnt_inc_i[0]=1 for one cycle → next cycle of_o=6'b000001, lcofi_pending_o=1; read 0xDA0 returns 0x8.
- Sticky OF and clear:
  - Repeat the wrap on counter 0 after lcofi_clr_i → OF stays 1, pending stays 0.
  - Write 0x323 with bit63=0, then wrap again → OF=1, pending=1.
- Clear/rise collision: PEND with lcofi_clr_i=1 in the same cycle as a wrap on counter 2 (OF[2]=0) → pending stays 1, of_o=6'b000101.
- Inhibit, RV64:
  - Write 0x324 = 64'h4000_0000_0000_0000, priv_lvl_i=2'b11 → mode_inhibit_o[1]=1 from the next cycle.
  - priv_lvl_i=2'b00 → mode_inhibit_o[1]=0.
  - Read 0x324 → 64'h4000_0000_0000_0000.
- Debug and CSR-wins: debug_mode_i=1 with a wrap on counter 5 → no OF, no pending. A CSR write of OF=0 to 0x328 in the same cycle as a wrap on counter 5 with debug_mode_i=0 → OF[5]=0, no pending.
